// File: rtl/sobel_pkg.sv
// Shared types, constants and arithmetic helpers for the Sobel gradient stage.
package sobel_pkg;

  localparam int TILE_DIM = 4;
  localparam int WIN_DIM  = 6;

  typedef logic [7:0] pixel_t;
  typedef pixel_t [WIN_DIM-1:0] pix_row_t;
  typedef pixel_t [WIN_DIM-1:0][WIN_DIM-1:0] window_t;

  typedef logic signed [8:0] grad_t;
  typedef grad_t [TILE_DIM-1:0] grad_row_t;
  typedef grad_t [TILE_DIM-1:0][TILE_DIM-1:0] tile_t;

  typedef logic signed [10:0] raw_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  function automatic raw_t px_ext(input pixel_t p);
    px_ext = raw_t'({3'b000, p});
  endfunction

  function automatic raw_t px2_ext(input pixel_t p);
    px2_ext = raw_t'({2'b00, p, 1'b0});
  endfunction

  // Clamp a scaled gradient into the 9-bit signed output range.
  function automatic grad_t sat_grad(input raw_t v);
    if (v > 11'sd255) begin
      sat_grad = 9'sd255;
    end else if (v < -11'sd256) begin
      sat_grad = 9'h100;
    end else begin
      sat_grad = v[8:0];
    end
  endfunction

endpackage

// File: rtl/sobel_row.sv
// Combinational Sobel kernel over three window rows: four scaled, saturated Gx/Gy pairs.
module sobel_row
  import sobel_pkg::*;
#(
  parameter int SHIFT = 2
) (
  input  logic [5:0][7:0] row_top,
  input  logic [5:0][7:0] row_mid,
  input  logic [5:0][7:0] row_bot,
  output logic [3:0][8:0] gx,
  output logic [3:0][8:0] gy
);

  for (genvar j = 0; j < TILE_DIM; j++) begin : g_col
    raw_t gx_raw_s;
    raw_t gy_raw_s;

    // Right column minus left column, centre row weighted by two.
    assign gx_raw_s = px_ext(row_top[j+2]) + px2_ext(row_mid[j+2]) + px_ext(row_bot[j+2])
                    - px_ext(row_top[j])   - px2_ext(row_mid[j])   - px_ext(row_bot[j]);

    // Bottom row minus top row, centre column weighted by two.
    assign gy_raw_s = px_ext(row_bot[j]) + px2_ext(row_bot[j+1]) + px_ext(row_bot[j+2])
                    - px_ext(row_top[j]) - px2_ext(row_top[j+1]) - px_ext(row_top[j+2]);

    assign gx[j] = sat_grad(gx_raw_s >>> SHIFT);
    assign gy[j] = sat_grad(gy_raw_s >>> SHIFT);
  end

endmodule

// File: rtl/sobel_gradient.sv
// Sobel gradient tile generator: captures a 6x6 window, computes one 4-wide output
// row per cycle, then holds the tile for the magnitude stage until acknowledged.
module sobel_gradient
  import sobel_pkg::*;
#(
  parameter int SHIFT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    grad_start,
  input  logic [5:0][5:0][7:0]    pix_in,
  output logic                    grad_busy,
  output logic                    mag_en,
  input  logic                    mag_done,
  output logic [3:0][3:0][8:0]    x_out,
  output logic [3:0][3:0][8:0]    y_out
);

  state_t    state_r;
  logic [1:0] row_r;
  window_t   win_r;

  logic [2:0] base_s;
  pix_row_t  row_top_s;
  pix_row_t  row_mid_s;
  pix_row_t  row_bot_s;
  grad_row_t gx_s;
  grad_row_t gy_s;

  // Select the three window rows feeding the current output row.
  assign base_s    = {1'b0, row_r};
  assign row_top_s = win_r[base_s];
  assign row_mid_s = win_r[base_s + 3'd1];
  assign row_bot_s = win_r[base_s + 3'd2];

  sobel_row #(
    .SHIFT (SHIFT)
  ) u_row (
    .row_top (row_top_s),
    .row_mid (row_mid_s),
    .row_bot (row_bot_s),
    .gx      (gx_s),
    .gy      (gy_s)
  );

  // Control FSM, window capture and row-by-row output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      row_r     <= 2'd0;
      win_r     <= '0;
      grad_busy <= 1'b0;
      mag_en    <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grad_start) begin
            win_r     <= pix_in;
            row_r     <= 2'd0;
            grad_busy <= 1'b1;
            state_r   <= ST_CALC;
          end
        end
        ST_CALC: begin
          x_out[row_r] <= gx_s;
          y_out[row_r] <= gy_s;
          row_r        <= row_r + 2'd1;
          if (row_r == 2'd3) begin
            mag_en  <= 1'b1;
            state_r <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (mag_done) begin
            mag_en    <= 1'b0;
            grad_busy <= 1'b0;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          mag_en    <= 1'b0;
          grad_busy <= 1'b0;
          row_r     <= 2'd0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_gradient.sv
// Randomized self-checking bench for sobel_gradient against a convolution reference model.
module tb_sobel_gradient;

  typedef logic [5:0][5:0][7:0] win_t;

  logic                 tb_clk = 1'b0;
  logic                 rst;
  logic                 grad_start;
  win_t                 pix_in;
  logic                 grad_busy;
  logic                 mag_en;
  logic                 mag_done;
  logic [3:0][3:0][8:0] x_out;
  logic [3:0][3:0][8:0] y_out;

  int n_checks = 0;
  int n_fail   = 0;

  sobel_gradient #(.SHIFT(2)) dut (
    .clk        (tb_clk),
    .rst        (rst),
    .grad_start (grad_start),
    .pix_in     (pix_in),
    .grad_busy  (grad_busy),
    .mag_en     (mag_en),
    .mag_done   (mag_done),
    .x_out      (x_out),
    .y_out      (y_out)
  );

  always #5 tb_clk = ~tb_clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // 3x3 Sobel convolution, floor-divided by 4 and clamped to 9-bit signed.
  function automatic int ref_grad(input win_t w, input int i, input int j, input bit is_y);
    int sum = 0;
    int wt;
    int q;
    for (int di = 0; di < 3; di++) begin
      for (int dj = 0; dj < 3; dj++) begin
        if (is_y) wt = (di - 1) * ((dj == 1) ? 2 : 1);
        else      wt = (dj - 1) * ((di == 1) ? 2 : 1);
        sum += wt * int'(w[i+di][j+dj]);
      end
    end
    q = (sum >= 0) ? (sum / 4) : -((-sum + 3) / 4);
    if (q > 255)  q = 255;
    if (q < -256) q = -256;
    return q;
  endfunction

  function automatic int sx9(input logic [8:0] v);
    return int'($signed(v));
  endfunction

  function automatic win_t make_win(input int mode);
    win_t w;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 6; c++) begin
        case (mode)
          0:       w[r][c] = 8'd100;
          1:       w[r][c] = (c >= 3) ? 8'd255 : 8'd0;
          2:       w[r][c] = (r <= 2) ? 8'd255 : 8'd0;
          3:       w[r][c] = (c <= 2) ? 8'd255 : 8'd0;
          default: w[r][c] = 8'($urandom_range(255, 0));
        endcase
      end
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic check_tile(input win_t w, input string tag);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        check_val($sformatf("%s_x%0d%0d", tag, i, j), sx9(x_out[i][j]), ref_grad(w, i, j, 1'b0));
        check_val($sformatf("%s_y%0d%0d", tag, i, j), sx9(y_out[i][j]), ref_grad(w, i, j, 1'b1));
      end
    end
  endtask

  task automatic check_cleared(input string tag);
    check_val({tag, "_busy"}, int'(grad_busy), 0);
    check_val({tag, "_mag_en"}, int'(mag_en), 0);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        check_val($sformatf("%s_x%0d%0d", tag, i, j), sx9(x_out[i][j]), 0);
        check_val($sformatf("%s_y%0d%0d", tag, i, j), sx9(y_out[i][j]), 0);
      end
    end
  endtask

  // Start a tile; a stray start pulse and changing pixels during CALC must be ignored.
  task automatic start_and_run(input win_t w, input string tag);
    pix_in     = w;
    grad_start = 1'b1;
    tick();
    grad_start = 1'b0;
    pix_in     = make_win(9);
    check_val({tag, "_busy_k"}, int'(grad_busy), 1);
    check_val({tag, "_mag_en_k"}, int'(mag_en), 0);
    for (int c = 1; c <= 3; c++) begin
      grad_start = (c == 2);
      tick();
      grad_start = 1'b0;
      check_val($sformatf("%s_mag_en_k%0d", tag, c), int'(mag_en), 0);
    end
    tick();
    check_val({tag, "_mag_en_k4"}, int'(mag_en), 1);
    check_val({tag, "_busy_k4"}, int'(grad_busy), 1);
    check_tile(w, tag);
  endtask

  task automatic release_tile(input string tag);
    mag_done = 1'b1;
    tick();
    mag_done = 1'b0;
    check_val({tag, "_rel_mag_en"}, int'(mag_en), 0);
    check_val({tag, "_rel_busy"}, int'(grad_busy), 0);
  endtask

  initial begin
    win_t w;
    win_t w2;
    rst        = 1'b1;
    grad_start = 1'b0;
    mag_done   = 1'b0;
    pix_in     = '0;
    tick();
    tick();
    check_cleared("reset_init");
    rst = 1'b0;
    tick();

    start_and_run(make_win(0), "flat");
    release_tile("flat");
    start_and_run(make_win(1), "vedge");
    release_tile("vedge");
    start_and_run(make_win(2), "hedge");
    release_tile("hedge");
    start_and_run(make_win(3), "vedge_rev");
    release_tile("vedge_rev");

    // Long hold with ignored start pulses, then back-to-back restart.
    w = make_win(9);
    start_and_run(w, "hold");
    for (int c = 0; c < 10; c++) begin
      grad_start = (c == 3 || c == 7);
      pix_in     = make_win(9);
      tick();
      grad_start = 1'b0;
      check_val($sformatf("hold_mag_en_c%0d", c), int'(mag_en), 1);
      check_tile(w, $sformatf("hold_c%0d", c));
    end
    release_tile("hold");
    w2 = make_win(9);
    start_and_run(w2, "restart");
    release_tile("restart");

    // mag_done already high on HOLD entry releases one cycle after entry.
    w = make_win(9);
    pix_in     = w;
    grad_start = 1'b1;
    tick();
    grad_start = 1'b0;
    mag_done   = 1'b1;
    for (int c = 1; c <= 3; c++) tick();
    tick();
    check_val("early_done_mag_en_k4", int'(mag_en), 1);
    check_tile(w, "early_done");
    tick();
    mag_done = 1'b0;
    check_val("early_done_mag_en_k5", int'(mag_en), 0);
    check_val("early_done_busy_k5", int'(grad_busy), 0);

    // Asynchronous reset after two rows of a CALC pass.
    pix_in     = make_win(1);
    grad_start = 1'b1;
    tick();
    grad_start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_cleared("reset_mid_calc");
    tick();
    rst = 1'b0;
    tick();
    start_and_run(make_win(2), "after_reset");
    release_tile("after_reset");

    for (int n = 0; n < 20; n++) begin
      int dly;
      w = make_win(9);
      start_and_run(w, $sformatf("rnd%0d", n));
      dly = $urandom_range(3, 0);
      for (int c = 0; c < dly; c++) begin
        tick();
        check_val($sformatf("rnd%0d_hold_mag_en", n), int'(mag_en), 1);
      end
      release_tile($sformatf("rnd%0d", n));
      if (n[0]) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_gradient.md
# sobel_gradient

- Produces the 4x4 tile of signed Sobel gradients that `magnitude` consumes.
- Takes a 6x6 unsigned 8-bit pixel window, computes Gx/Gy for the 16 interior 3x3 neighbourhoods one output row per cycle, then scales and saturates each result to 9-bit signed.
- Presents the tile on `x_out`/`y_out` and holds it under the `mag_en`/`mag_done` handshake until `magnitude` acknowledges it.
- Sits between the window buffer and `magnitude` in the edge-detection datapath.

## Interface
Parameters:
- SHIFT, 2, arithmetic right-shift applied to raw 11-bit gradients before saturation to 9 bits.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- grad_start  in  1  window valid; sampled only in IDLE.
- pix_in  in  [5:0][5:0][7:0]  unsigned window, [row][col].
- grad_busy  out  1  high in any state other than IDLE.
- mag_en  out  1  tile valid; high for the whole HOLD state.
- mag_done  in  1  tile accepted; sampled only in HOLD.
- x_out  out  [3:0][3:0][8:0]  signed Gx tile, [row][col].
- y_out  out  [3:0][3:0][8:0]  signed Gy tile, [row][col].

## Operation
- States: IDLE, CALC, HOLD.
- IDLE: on `grad_start`=1, register `pix_in` into the internal window, clear row counter `r`, go to CALC.
- CALC: each cycle, write row r of `x_out`/`y_out` from the registered window.
  - r increments 0..3.
  - At r=3 the state goes to HOLD.
- HOLD: `mag_en`=1; `x_out`/`y_out` stable. On `mag_done`=1 go to IDLE.
- For output (i,j), with p = registered window:
  - Gx = (p[i][j+2] + 2p[i+1][j+2] + p[i+2][j+2]) − (p[i][j] + 2p[i+1][j] + p[i+2][j]).
  - Gy = (p[i+2][j] + 2p[i+2][j+1] + p[i+2][j+2]) − (p[i][j] + 2p[i][j+1] + p[i][j+2]).
- Width rules:
  - Raw gradients are 11-bit signed, range ±1020.
  - Result = raw >>> SHIFT (arithmetic, floor), saturated to [−256, 255].
  - With SHIFT=2 the range is ±255 and saturation never fires.
- Ignored inputs:
  - `grad_start` in CALC/HOLD, with no queuing.
  - `mag_done` in IDLE/CALC.
  - `pix_in` outside the IDLE capture edge.
- Outputs keep the previous tile until overwritten row by row in the next CALC; `magnitude` must sample only while `mag_en`=1.

## Timing
- Reset values: state IDLE, r=0, `grad_busy`=0, `mag_en`=0, all `x_out`/`y_out` elements 0, window registers 0.
- Let `grad_start` be sampled at edge k:
  - `grad_busy`=1 after edge k.
  - Row 0 is written at edge k+1, row 3 at edge k+4.
  - `mag_en`=1 after edge k+4.
  - Start-to-valid latency is 4 cycles.
- If `mag_done` is sampled at edge m in HOLD, `mag_en`=0 and `grad_busy`=0 after edge m.
  - The earliest new `grad_start` is accepted at edge m+1.
- `mag_done` held high across the HOLD entry edge is not seen until the first HOLD cycle; it then releases the tile at the next edge.
- Asserting `rst` in any state, including mid-CALC or HOLD, forces the reset values immediately, with no clock needed.

## Structure
- `sobel_pkg` holds:
  - pixel_t (8-bit unsigned), window_t ([5:0][5:0]pixel_t).
  - grad_t (9-bit signed), tile_t ([3:0][3:0]grad_t).
  - raw_t (11-bit signed), the state enum, and the constants TILE_DIM=4, WIN_DIM=6.
- One sub-module, `sobel_row`: combinational; takes three window rows and produces four scaled, saturated Gx/Gy pairs.
  - The top level instantiates it once and muxes the window rows with r.
- Top level holds the FSM, row counter, window register and output registers.

## Test plan
- Reset: assert `rst` mid-simulation → all outputs 0, `grad_busy`=0, `mag_en`=0 with no clock edge.
- Flat window, all pixels 100, `grad_start` pulse → `mag_en` rises after 4 edges; all x/y outputs 0.
- Vertical edge, cols 0–2 = 0 and cols 3–5 = 255 → every row of x_out is [j0..j3] = 0, 255, 255, 0; all y_out 0.
- Horizontal edge, rows 0–2 = 255 and rows 3–5 = 0 → y_out rows 1,2 = −255 in every column, rows 0,3 = 0; all x_out 0.
- Handshake:
  - Hold `mag_done`=0 for 10 cycles in HOLD → `mag_en` stays 1 and the tile is stable.
  - Pulse `grad_start` during CALC and HOLD → ignored.
  - Pulse `mag_done` → IDLE the next cycle; a new start is accepted one cycle later.
- Reset mid-CALC after 2 rows are written → outputs cleared, IDLE; a following full run produces the correct tile.
